// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: 2-flop synchroniser, stability counter, level and edge pulses.
// Optional long-press hold pulse per channel when DEBOUNCE_HOLD_EN is defined.
module debounce_bank #(
  parameter int unsigned       NUM_CH         = 4,
  parameter int unsigned       DEBOUNCE_LIMIT = 250_000,
  parameter logic [NUM_CH-1:0] RST_VALUE      = '0,
  parameter int unsigned       HOLD_LIMIT     = 25_000_000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic              o_Any_Change,
  output logic [NUM_CH-1:0] o_Hold
);

  localparam int unsigned        CNT_W   = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [NUM_CH-1:0] r_s1;
  logic [NUM_CH-1:0] r_s2;
  logic [NUM_CH-1:0] r_switch;
  logic [NUM_CH-1:0] r_rise;
  logic [NUM_CH-1:0] r_fall;
  logic              r_any;
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [NUM_CH-1:0] w_diff;
  logic [NUM_CH-1:0] w_accept;

  // Synchroniser for the asynchronous pins.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_s1 <= RST_VALUE;
      r_s2 <= RST_VALUE;
    end else begin
      r_s1 <= i_Switch;
      r_s2 <= r_s1;
    end
  end

  // A channel flips on the DEBOUNCE_LIMIT-th consecutive differing sample.
  always_comb begin
    w_diff   = r_s2 ^ r_switch;
    w_accept = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      w_accept[i] = w_diff[i] && (r_cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_switch <= RST_VALUE;
      r_rise   <= '0;
      r_fall   <= '0;
      r_any    <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_switch <= r_switch ^ w_accept;
      r_rise   <= w_accept & r_s2;
      r_fall   <= w_accept & ~r_s2;
      r_any    <= |w_accept;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (!w_diff[i] || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign o_Switch     = r_switch;
  assign o_Rise       = r_rise;
  assign o_Fall       = r_fall;
  assign o_Any_Change = r_any;

`ifdef DEBOUNCE_HOLD_EN
  localparam int unsigned       HOLD_W   = $clog2(HOLD_LIMIT + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LIMIT);

  logic [HOLD_W-1:0] r_hold_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_hold;

  // Hold counter saturates at HOLD_MAX so each press yields a single pulse.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_hold <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        r_hold_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (!r_switch[i]) begin
          r_hold_cnt[i] <= '0;
          r_hold[i]     <= 1'b0;
        end else if (r_hold_cnt[i] != HOLD_MAX) begin
          r_hold_cnt[i] <= r_hold_cnt[i] + HOLD_W'(1);
          r_hold[i]     <= (r_hold_cnt[i] == HOLD_MAX - HOLD_W'(1));
        end else begin
          r_hold[i]     <= 1'b0;
        end
      end
    end
  end

  assign o_Hold = r_hold;
`else
  // HOLD_LIMIT has no consumer when the hold feature is left out.
  logic w_unused_hold;
  assign w_unused_hold = (HOLD_LIMIT != 0);
  assign o_Hold        = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Directed self-checking bench for debounce_bank (NUM_CH=4, DEBOUNCE_LIMIT=4, HOLD_LIMIT=10).
module tb_debounce_bank;

  logic       i_Clk;
  logic       i_Rst_n;
  logic [3:0] i_Switch;
  logic [3:0] o_Switch;
  logic [3:0] o_Rise;
  logic [3:0] o_Fall;
  logic       o_Any_Change;
  logic [3:0] o_Hold;

  int checks = 0;
  int errors = 0;

`ifdef DEBOUNCE_HOLD_EN
  localparam logic [3:0] HOLD_EXP = 4'b0001;
`else
  localparam logic [3:0] HOLD_EXP = 4'b0000;
`endif

  debounce_bank #(
    .NUM_CH        (4),
    .DEBOUNCE_LIMIT(4),
    .RST_VALUE     (4'b0000),
    .HOLD_LIMIT    (10)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst_n     (i_Rst_n),
    .i_Switch    (i_Switch),
    .o_Switch    (o_Switch),
    .o_Rise      (o_Rise),
    .o_Fall      (o_Fall),
    .o_Any_Change(o_Any_Change),
    .o_Hold      (o_Hold)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  // One clock edge, then sample 1 time unit later; without the hold feature o_Hold must stay 0.
  task automatic step();
    @(posedge i_Clk);
    #1;
`ifndef DEBOUNCE_HOLD_EN
    checks++;
    if (o_Hold !== 4'b0000) begin
      errors++;
      $display("FAIL hold_tied_off actual=%b required=0000", o_Hold);
    end
`endif
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic apply_reset(input logic [3:0] sw);
    i_Switch = sw;
    i_Rst_n  = 1'b0;
    #1;
    steps(2);
    i_Rst_n  = 1'b1;
  endtask

  task automatic test_reset();
    i_Rst_n  = 1'b1;
    i_Switch = 4'b1111;
    #3 i_Rst_n = 1'b0;
    #1;
    checks++;
    if ({o_Switch, o_Rise, o_Fall, o_Any_Change, o_Hold} !== 17'd0) begin
      errors++;
      $display("FAIL reset_async actual=%b required=0", {o_Switch, o_Rise, o_Fall, o_Any_Change, o_Hold});
    end
    steps(3);
    checks++;
    if ({o_Switch, o_Rise, o_Fall, o_Any_Change, o_Hold} !== 17'd0) begin
      errors++;
      $display("FAIL reset_held actual=%b required=0", {o_Switch, o_Rise, o_Fall, o_Any_Change, o_Hold});
    end
    i_Rst_n = 1'b1;
    steps(5);
    checks++;
    if (o_Switch !== 4'b0000) begin
      errors++;
      $display("FAIL reset_edge4 o_Switch actual=%b required=0000", o_Switch);
    end
    step();
    checks++;
    if (o_Switch !== 4'b1111 || o_Rise !== 4'b1111 || o_Fall !== 4'b0000 || o_Any_Change !== 1'b1) begin
      errors++;
      $display("FAIL reset_edge5 sw=%b rise=%b fall=%b any=%b required sw=1111 rise=1111 fall=0000 any=1",
               o_Switch, o_Rise, o_Fall, o_Any_Change);
    end
    step();
    checks++;
    if (o_Switch !== 4'b1111 || o_Rise !== 4'b0000 || o_Any_Change !== 1'b0) begin
      errors++;
      $display("FAIL reset_edge6 sw=%b rise=%b any=%b required sw=1111 rise=0000 any=0",
               o_Switch, o_Rise, o_Any_Change);
    end
    // Simultaneous falls on channels 1 and 3.
    i_Switch = 4'b0101;
    steps(5);
    checks++;
    if (o_Switch !== 4'b1111 || o_Fall !== 4'b0000) begin
      errors++;
      $display("FAIL multi_fall_early sw=%b fall=%b required sw=1111 fall=0000", o_Switch, o_Fall);
    end
    step();
    checks++;
    if (o_Switch !== 4'b0101 || o_Fall !== 4'b1010 || o_Rise !== 4'b0000 || o_Any_Change !== 1'b1) begin
      errors++;
      $display("FAIL multi_fall sw=%b rise=%b fall=%b any=%b required sw=0101 rise=0000 fall=1010 any=1",
               o_Switch, o_Rise, o_Fall, o_Any_Change);
    end
  endtask

  task automatic test_rise_fall();
    apply_reset(4'b0000);
    step();
    i_Switch = 4'b0001;
    steps(5);
    checks++;
    if (o_Switch !== 4'b0000 || o_Rise !== 4'b0000) begin
      errors++;
      $display("FAIL rise_edge4 sw=%b rise=%b required sw=0000 rise=0000", o_Switch, o_Rise);
    end
    step();
    checks++;
    if (o_Switch !== 4'b0001 || o_Rise !== 4'b0001 || o_Fall !== 4'b0000 || o_Any_Change !== 1'b1) begin
      errors++;
      $display("FAIL rise_edge5 sw=%b rise=%b fall=%b any=%b required sw=0001 rise=0001 fall=0000 any=1",
               o_Switch, o_Rise, o_Fall, o_Any_Change);
    end
    step();
    checks++;
    if (o_Switch !== 4'b0001 || o_Rise !== 4'b0000 || o_Fall !== 4'b0000 || o_Any_Change !== 1'b0) begin
      errors++;
      $display("FAIL rise_edge6 sw=%b rise=%b fall=%b any=%b required sw=0001 rise=0000 fall=0000 any=0",
               o_Switch, o_Rise, o_Fall, o_Any_Change);
    end
    i_Switch = 4'b0000;
    steps(6);
    checks++;
    if (o_Switch !== 4'b0000 || o_Fall !== 4'b0001 || o_Rise !== 4'b0000) begin
      errors++;
      $display("FAIL fall_edge5 sw=%b rise=%b fall=%b required sw=0000 rise=0000 fall=0001",
               o_Switch, o_Rise, o_Fall);
    end
  endtask

  task automatic test_chatter();
    int bad;
    apply_reset(4'b0000);
    step();
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      i_Switch[1] = ((k / 2) % 2 == 0);
      step();
      if (o_Switch !== 4'b0000 || o_Rise !== 4'b0000 || o_Fall !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL chatter_stable actual=%0d bad cycles required=0", bad);
    end
    i_Switch[1] = 1'b1;
    steps(5);
    checks++;
    if (o_Switch !== 4'b0000) begin
      errors++;
      $display("FAIL chatter_settle_edge4 sw=%b required=0000", o_Switch);
    end
    step();
    checks++;
    if (o_Switch !== 4'b0010 || o_Rise !== 4'b0010) begin
      errors++;
      $display("FAIL chatter_settle_edge5 sw=%b rise=%b required sw=0010 rise=0010", o_Switch, o_Rise);
    end
  endtask

  task automatic test_glitch();
    apply_reset(4'b0000);
    step();
    i_Switch[2] = 1'b1;
    steps(3);
    i_Switch[2] = 1'b0;
    step();
    i_Switch[2] = 1'b1;
    // Counter restarts on the glitch sample: acceptance only 6 edges after the final 0->1.
    steps(5);
    checks++;
    if (o_Switch !== 4'b0000 || o_Rise !== 4'b0000) begin
      errors++;
      $display("FAIL glitch_edge4 sw=%b rise=%b required sw=0000 rise=0000", o_Switch, o_Rise);
    end
    step();
    checks++;
    if (o_Switch !== 4'b0100 || o_Rise !== 4'b0100 || o_Any_Change !== 1'b1) begin
      errors++;
      $display("FAIL glitch_edge5 sw=%b rise=%b any=%b required sw=0100 rise=0100 any=1",
               o_Switch, o_Rise, o_Any_Change);
    end
  endtask

  task automatic test_reset_mid_count();
    apply_reset(4'b0000);
    step();
    i_Switch = 4'b1000;
    steps(5);
    i_Rst_n = 1'b0;
    #1;
    checks++;
    if (o_Switch !== 4'b0000 || o_Rise !== 4'b0000 || o_Any_Change !== 1'b0) begin
      errors++;
      $display("FAIL midreset_assert sw=%b rise=%b any=%b required 0000/0000/0", o_Switch, o_Rise, o_Any_Change);
    end
    steps(2);
    i_Rst_n = 1'b1;
    steps(5);
    checks++;
    if (o_Switch !== 4'b0000 || o_Rise !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_edge4 sw=%b rise=%b required sw=0000 rise=0000", o_Switch, o_Rise);
    end
    step();
    checks++;
    if (o_Switch !== 4'b1000 || o_Rise !== 4'b1000) begin
      errors++;
      $display("FAIL midreset_edge5 sw=%b rise=%b required sw=1000 rise=1000", o_Switch, o_Rise);
    end
  endtask

  task automatic press_and_hold(input string tag);
    int bad;
    i_Switch = 4'b0001;
    steps(6);
    checks++;
    if (o_Switch !== 4'b0001 || o_Rise !== 4'b0001) begin
      errors++;
      $display("FAIL %s_rise sw=%b rise=%b required sw=0001 rise=0001", tag, o_Switch, o_Rise);
    end
    bad = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      if (o_Hold !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_early actual=%0d cycles with hold required=0", tag, bad);
    end
    step();
    checks++;
    if (o_Hold !== HOLD_EXP) begin
      errors++;
      $display("FAIL %s_pulse o_Hold actual=%b required=%b", tag, o_Hold, HOLD_EXP);
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (o_Hold !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_repeat actual=%0d cycles with hold required=0", tag, bad);
    end
  endtask

  task automatic test_hold();
    apply_reset(4'b0000);
    step();
    press_and_hold("hold1");
    i_Switch = 4'b0000;
    steps(6);
    checks++;
    if (o_Switch !== 4'b0000 || o_Fall !== 4'b0001 || o_Hold !== 4'b0000) begin
      errors++;
      $display("FAIL hold_release sw=%b fall=%b hold=%b required sw=0000 fall=0001 hold=0000",
               o_Switch, o_Fall, o_Hold);
    end
    press_and_hold("hold2");
  endtask

  initial begin
    i_Rst_n  = 1'b1;
    i_Switch = 4'b0000;
    test_reset();
    test_rise_fall();
    test_chatter();
    test_glitch();
    test_reset_mid_count();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
